// File: rtl/keks_pkg.sv
// Shared constants and types for the Keks gamepad receive path.
package keks_pkg;

  localparam int GP_FRAME_BITS = 120;

  localparam logic [7:0] GP_DIR_UP = 8'h01;
  localparam logic [7:0] GP_DIR_DN = 8'h05;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_ERR
  } rx_state_t;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_ff2 (
  input  logic clk_100mhz,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_100mhz) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rp_gamepad_rx.sv
// RP2040 gamepad link receiver: oversamples sclk/mosi, frames fixed-length
// words delimited by idle gaps, publishes the last good frame and decodes it.
module rp_gamepad_rx
  import keks_pkg::*;
#(
  parameter int         FRAME_BITS   = GP_FRAME_BITS,
  parameter int         IDLE_CYCLES  = 2000,
  parameter int         STALE_CYCLES = 10_000_000,
  parameter int         DIR_LSB      = 64,
  parameter int         BTN_LSB      = 56,
  parameter logic [7:0] UP_CODE      = GP_DIR_UP,
  parameter logic [7:0] DN_CODE      = GP_DIR_DN
) (
  input  logic                  clk_100mhz,
  input  logic                  resetn,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic [FRAME_BITS-1:0] ldata,
  output logic                  frame_stb,
  output logic                  frame_tgl,
  output logic [7:0]            dir,
  output logic [7:0]            btns,
  output logic                  btn_up,
  output logic                  btn_dn,
  output logic                  btn_fire,
  output logic                  link_ok,
  output logic [7:0]            err_cnt
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  logic                  sclk_s, mosi_s, sclk_q;
  logic                  rise;
  logic [FRAME_BITS-1:0] shreg;
  logic [BW-1:0]         bitcnt;
  logic [IW-1:0]         idlecnt;
  logic [SW-1:0]         stale_cnt;
  logic                  idle_full;
  rx_state_t             state, state_nxt;
  logic                  do_shift, do_commit, do_err;

  sync_ff2 u_sync_sclk (.clk_100mhz(clk_100mhz), .resetn(resetn), .d(sclk), .q(sclk_s));
  sync_ff2 u_sync_mosi (.clk_100mhz(clk_100mhz), .resetn(resetn), .d(mosi), .q(mosi_s));

  assign rise      = sclk_s & ~sclk_q;
  assign idle_full = (idlecnt == IW'(IDLE_CYCLES));

  // A rise always takes priority over a gap that completes on the same clock.
  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    do_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          do_shift  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rise) begin
          do_shift = 1'b1;
          if (bitcnt == BW'(FRAME_BITS - 1)) state_nxt = S_GAP;
        end else if (idle_full) begin
          do_err    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (rise) begin
          state_nxt = S_ERR;
        end else if (idle_full) begin
          do_commit = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        if (!rise && idle_full) begin
          do_err    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (!resetn) begin
      state     <= S_IDLE;
      sclk_q    <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      idlecnt   <= '0;
      stale_cnt <= '0;
      ldata     <= '0;
      frame_stb <= 1'b0;
      frame_tgl <= 1'b0;
      dir       <= '0;
      btns      <= '0;
      btn_up    <= 1'b0;
      btn_dn    <= 1'b0;
      btn_fire  <= 1'b0;
      link_ok   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      sclk_q    <= sclk_s;
      frame_stb <= 1'b0;

      if (rise) idlecnt <= '0;
      else if (!idle_full) idlecnt <= idlecnt + 1'b1;

      // Expiry is written first so a coincident commit overrides it below.
      if (stale_cnt != SW'(STALE_CYCLES)) stale_cnt <= stale_cnt + 1'b1;
      if (stale_cnt == SW'(STALE_CYCLES - 1)) begin
        link_ok  <= 1'b0;
        btn_up   <= 1'b0;
        btn_dn   <= 1'b0;
        btn_fire <= 1'b0;
      end

      if (do_shift) begin
        shreg  <= {shreg[FRAME_BITS-2:0], mosi_s};
        bitcnt <= bitcnt + 1'b1;
      end

      if (do_err) begin
        bitcnt <= '0;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end

      if (do_commit) begin
        ldata     <= shreg;
        frame_stb <= 1'b1;
        frame_tgl <= ~frame_tgl;
        stale_cnt <= '0;
        link_ok   <= 1'b1;
        bitcnt    <= '0;
        dir       <= shreg[DIR_LSB+:8];
        btns      <= shreg[BTN_LSB+:8];
        btn_up    <= (shreg[DIR_LSB+:8] == UP_CODE);
        btn_dn    <= (shreg[DIR_LSB+:8] == DN_CODE);
        btn_fire  <= |shreg[BTN_LSB+:4];
      end
    end
  end

endmodule

// File: tb/tb_rp_gamepad_rx.sv
// Randomized bench for rp_gamepad_rx against a frame-level reference model.
module tb_rp_gamepad_rx;

  localparam int FB    = 120;
  localparam int IDLE  = 32;
  localparam int STALE = 12000;

  logic          clk_100mhz = 1'b0;
  logic          resetn     = 1'b0;
  logic          sclk       = 1'b0;
  logic          mosi       = 1'b0;
  logic [FB-1:0] ldata;
  logic          frame_stb, frame_tgl, btn_up, btn_dn, btn_fire, link_ok;
  logic [7:0]    dir, btns, err_cnt;

  rp_gamepad_rx #(
    .FRAME_BITS  (FB),
    .IDLE_CYCLES (IDLE),
    .STALE_CYCLES(STALE)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .resetn    (resetn),
    .sclk      (sclk),
    .mosi      (mosi),
    .ldata     (ldata),
    .frame_stb (frame_stb),
    .frame_tgl (frame_tgl),
    .dir       (dir),
    .btns      (btns),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .btn_fire  (btn_fire),
    .link_ok   (link_ok),
    .err_cnt   (err_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  int stb_seen = 0;
  int stb_cyc  = 0;
  always @(negedge clk_100mhz) begin
    if (frame_stb === 1'b1) begin
      stb_seen <= stb_seen + 1;
      stb_cyc  <= cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model: what the link should have published, in frame terms.
  logic [FB-1:0] m_ldata = '0;
  int            m_err   = 0;
  int            m_stb   = 0;
  logic          m_tgl   = 1'b0;
  bit            m_have  = 1'b0;
  int            m_good_end = 0;
  int            last_rise  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic send(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      sclk = 1'b0;
      repeat ($urandom_range(4, 6)) @(posedge clk_100mhz);
      #1;
      sclk      = 1'b1;
      last_rise = cyc;
      repeat ($urandom_range(4, 6)) @(posedge clk_100mhz);
      #1;
    end
  endtask

  task automatic gap();
    sclk = 1'b0;
    repeat (IDLE + 12) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic check_all();
    int   elapsed;
    bit   exp_link;
    logic [7:0] ed, eb;
    @(negedge clk_100mhz);
    ed = m_ldata[71:64];
    eb = m_ldata[63:56];
    chk("stb_count", stb_seen, m_stb);
    chk("err_cnt", err_cnt, m_err);
    chk("ldata", ldata, m_ldata);
    chk("dir", dir, ed);
    chk("btns", btns, eb);
    chk("frame_tgl", frame_tgl, m_tgl);
    elapsed  = cyc - (m_good_end + IDLE + 4);
    exp_link = m_have && (elapsed < STALE);
    if (!m_have || elapsed < STALE - 3 || elapsed > STALE + 3) begin
      chk("link_ok", link_ok, exp_link);
      chk("btn_up", btn_up, exp_link && ed == 8'h01);
      chk("btn_dn", btn_dn, exp_link && ed == 8'h05);
      chk("btn_fire", btn_fire, exp_link && eb[3:0] != 4'h0);
    end
  endtask

  task automatic xfer(input logic [127:0] v, input int n);
    send(v, n);
    gap();
    if (n == FB) begin
      m_ldata    = v[FB-1:0];
      m_stb++;
      m_tgl      = ~m_tgl;
      m_have     = 1'b1;
      m_good_end = last_rise;
    end else if (m_err < 255) begin
      m_err++;
    end
    check_all();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v;
    int           n, sel, target;

    repeat (4) @(posedge clk_100mhz);
    #1;
    check_all();
    chk("reset_stb", frame_stb, 1'b0);
    resetn = 1'b1;
    repeat (3) @(posedge clk_100mhz);
    #1;

    // T1: up-code frame, commit latency after the last sclk rise
    v = rnd128();
    v[71:64] = 8'h01;
    v[63:56] = 8'h00;
    xfer(v, FB);
    chk("t1_latency", (stb_cyc - last_rise >= IDLE + 3) && (stb_cyc - last_rise <= IDLE + 4), 1'b1);
    chk("t1_btn_up", btn_up, 1'b1);

    // T2: short frame, then a good one
    xfer(rnd128(), 100);
    xfer(rnd128(), FB);

    // T3: overlength frame
    xfer(rnd128(), FB + 1);

    // Mixed random traffic
    for (int k = 0; k < 6; k++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2)       n = FB;
      else if (sel == 2) n = $urandom_range(1, FB - 1);
      else               n = $urandom_range(FB + 1, 126);
      xfer(rnd128(), n);
    end

    // T5: reset in the middle of a frame
    send(rnd128(), 60);
    sclk = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    #1;
    resetn = 1'b0;
    @(posedge clk_100mhz);
    #1;
    resetn = 1'b1;
    m_ldata = '0;
    m_err   = 0;
    m_tgl   = 1'b0;
    m_have  = 1'b0;
    check_all();
    xfer(rnd128(), FB);

    // T4: down + fire frame, then silence until the link goes stale
    v = rnd128();
    v[71:64] = 8'h05;
    v[63:56] = 8'h04;
    xfer(v, FB);
    chk("t4_btn_dn", btn_dn, 1'b1);
    chk("t4_btn_fire", btn_fire, 1'b1);
    target = m_good_end + IDLE + 4 + STALE;
    while (cyc < target - 4) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    chk("t4_link_before", link_ok, 1'b1);
    while (cyc < target + 3) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    chk("t4_link_after", link_ok, 1'b0);
    chk("t4_dn_after", btn_dn, 1'b0);
    chk("t4_fire_after", btn_fire, 1'b0);
    chk("t4_dir_held", dir, 8'h05);
    chk("t4_btns_held", btns, 8'h04);
    chk("t4_ldata_held", ldata, m_ldata);

    // T6: many short frames saturate the error counter
    for (int k = 0; k < 260; k++) xfer(rnd128(), $urandom_range(1, 8));
    chk("t6_err_sat", err_cnt, 8'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
